adc_window_stats: RTL
=====================

Name: adc_window_stats

Overview:
- Sits directly downstream of the dual-channel 12-bit SPI ADC front end.
- Consumes its one-cycle sample strobe and both channel words.
- Accumulates fixed-length windows of 2^LOG2_N samples per channel and produces a per-channel average, minimum and maximum.
- Presents each window result to the measurement readout logic over a valid/ready handshake, with a sticky overrun flag when results are not consumed in time.

Parameters:
- LOG2_N, default 4: window length is 2^LOG2_N samples; legal range 0..8.

Ports:
- clk  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- en_i  input  1  enable; low aborts the current window and holds the block idle
- clr_i  input  1  synchronous clear of window state, pending result and overrun flag
- sample_valid_i  input  1  one-cycle strobe, new ADC sample present
- data0_i  input  12  ADC channel 0 sample, valid with strobe
- data1_i  input  12  ADC channel 1 sample, valid with strobe
- res_valid_o  output  1  window result available
- res_ready_i  input  1  consumer accepts result
- avg0_o  output  12  channel 0 window average
- avg1_o  output  12  channel 1 window average
- min0_o  output  12  channel 0 window minimum
- max0_o  output  12  channel 0 window maximum
- min1_o  output  12  channel 1 window minimum
- max1_o  output  12  channel 1 window maximum
- overrun_o  output  1  sticky: a pending result was overwritten

Behaviour:
- Reset: all result outputs 0x000, res_valid_o 0, overrun_o 0, FSM IDLE, sample counter 0.
- Internal reset state: accumulators 0, running min 0xFFF, running max 0x000.
- FSM has two states, IDLE and ACC.
- IDLE:
  - Accumulators, counter and running min/max are held at their initial values.
  - Strobes are ignored.
  - Go to ACC when en_i=1.
- ACC:
  - On each strobe: sum_x += data_x (width 12+LOG2_N, cannot overflow); min_x/max_x updated; counter += 1.
  - Go to IDLE when en_i=0. The partial window is discarded and all window state is reinitialised.
- Window close: a strobe arriving with counter == 2^LOG2_N-1 closes the window.
  - Next cycle: avg_x_o = (sum_x + data_x) >> LOG2_N, truncating.
  - Next cycle: min/max outputs include the closing sample.
  - Next cycle: res_valid_o = 1.
  - In the same closing cycle, counter, sums and min/max restart at their initial values. No gap; the next strobe belongs to the new window.
- LOG2_N=0: every strobe closes a window; avg = min = max = the sample.
- Latency: result registered exactly 1 cycle after the closing strobe.
- Handshake:
  - Outputs are stable while res_valid_o=1 and res_ready_i=0.
  - Transfer occurs when res_valid_o & res_ready_i; res_valid_o drops the next cycle unless a new result is loaded.
  - res_ready_i is ignored while res_valid_o=0.
- Overrun: a window closes while res_valid_o=1 and no transfer happens that cycle.
  - Outputs are overwritten with the new result, res_valid_o stays 1, overrun_o set.
- Simultaneous transfer and window close: the new result loads, res_valid_o stays 1, overrun_o not set.
- overrun_o clears only on clr_i or reset.
- clr_i:
  - Clears window state, res_valid_o and overrun_o next cycle. Result data outputs retain their values.
  - Has priority over a strobe in the same cycle; that sample is dropped.
  - The FSM stays in ACC if en_i=1.
- en_i=0 while res_valid_o=1: the pending result is retained until transferred or cleared.
- Strobes on consecutive cycles must be handled without loss.

Test Plan:
- LOG2_N=2, ch0 samples 100,200,300,401, ch1 samples 0,0,0,4095 -> one cycle after the 4th strobe, res_valid_o=1:
  - ch0: avg0=250, min0=100, max0=401.
  - ch1: avg1=1023, min1=0, max1=4095.
- LOG2_N=4, 16 strobes of 0xFFF on both channels -> avg=0xFFF, min=max=0xFFF, no accumulator wrap.
- Backpressure: res_ready_i=0 across two LOG2_N=2 windows -> second window's values on outputs, overrun_o=1. overrun_o remains 1 after a transfer and clears only after a clr_i pulse.
- Coincident closing strobe and res_ready_i=1 with res_valid_o=1 -> new result loaded, res_valid_o stays 1, overrun_o=0.
- en_i dropped after 2 of 4 samples (50,60), then re-enabled with samples 10,20,30,40 -> single result avg0=25, min0=10, max0=40.
- Back-to-back strobes of 8 samples 1..8, LOG2_N=2 -> two results: avg 2/min 1/max 4, then avg 6/min 5/max 8. No sample is lost at the boundary.

Source files
------------

// File: rtl/adc_window_stats.sv
// Per-channel average/min/max over windows of 2^LOG2_N ADC samples; result registered 1 cycle after the closing strobe.
// Result held under res_ready_i=0; a new window close overwrites it and sets the sticky overrun flag.
module adc_window_stats #(
  parameter int LOG2_N = 4
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic        sample_valid_i,
  input  logic [11:0] data0_i,
  input  logic [11:0] data1_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [11:0] avg0_o,
  output logic [11:0] avg1_o,
  output logic [11:0] min0_o,
  output logic [11:0] max0_o,
  output logic [11:0] min1_o,
  output logic [11:0] max1_o,
  output logic        overrun_o
);

  localparam int SW = 12 + LOG2_N;
  // One spare counter bit keeps the width non-zero when LOG2_N is 0.
  localparam int CW = LOG2_N + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_N) - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  logic [0:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] sum0_q, sum1_q;
  logic [11:0]   mn0_q, mx0_q, mn1_q, mx1_q;

  logic          take, close, xfer;
  logic [SW-1:0] sum0_n, sum1_n;
  logic [11:0]   mn0_n, mx0_n, mn1_n, mx1_n;

  assign take  = (state_q == ST_ACC) && en_i && !clr_i && sample_valid_i;
  assign close = take && (cnt_q == LAST);
  assign xfer  = res_valid_o && res_ready_i;

  assign sum0_n = sum0_q + SW'(data0_i);
  assign sum1_n = sum1_q + SW'(data1_i);
  assign mn0_n  = (data0_i < mn0_q) ? data0_i : mn0_q;
  assign mx0_n  = (data0_i > mx0_q) ? data0_i : mx0_q;
  assign mn1_n  = (data1_i < mn1_q) ? data1_i : mn1_q;
  assign mx1_n  = (data1_i > mx1_q) ? data1_i : mx1_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= en_i ? ST_ACC : ST_IDLE;
    end
  end

  // Window state restarts on close in the same cycle, so back-to-back strobes roll straight into the next window.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sum0_q <= '0;
      sum1_q <= '0;
      mn0_q  <= 12'hFFF;
      mx0_q  <= 12'h000;
      mn1_q  <= 12'hFFF;
      mx1_q  <= 12'h000;
    end else if (!en_i || (state_q == ST_IDLE) || clr_i || close) begin
      cnt_q  <= '0;
      sum0_q <= '0;
      sum1_q <= '0;
      mn0_q  <= 12'hFFF;
      mx0_q  <= 12'h000;
      mn1_q  <= 12'hFFF;
      mx1_q  <= 12'h000;
    end else if (take) begin
      cnt_q  <= cnt_q + CW'(1);
      sum0_q <= sum0_n;
      sum1_q <= sum1_n;
      mn0_q  <= mn0_n;
      mx0_q  <= mx0_n;
      mn1_q  <= mn1_n;
      mx1_q  <= mx1_n;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      avg0_o <= '0;
      avg1_o <= '0;
      min0_o <= '0;
      max0_o <= '0;
      min1_o <= '0;
      max1_o <= '0;
    end else if (close) begin
      avg0_o <= sum0_n[LOG2_N +: 12];
      avg1_o <= sum1_n[LOG2_N +: 12];
      min0_o <= mn0_n;
      max0_o <= mx0_n;
      min1_o <= mn1_n;
      max1_o <= mx1_n;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else if (clr_i) begin
      res_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (close) begin
        res_valid_o <= 1'b1;
      end else if (xfer) begin
        res_valid_o <= 1'b0;
      end
      if (close && res_valid_o && !res_ready_i) begin
        overrun_o <= 1'b1;
      end
    end
  end

endmodule
